// File: rtl/mem_pkg.sv
// mem_pkg: shared types and widths for the unified memory unit.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;
  localparam int WORD_W = 32;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_if.sv
// mem_if: controller-to-memory request/ready bus.
interface mem_if;
  import mem_pkg::*;
  logic req;
  logic we;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] wd;
  logic [WORD_W-1:0] rd;
  logic ready;
  logic busy;
  logic misalign;
  modport master (output req, we, addr, wd, input rd, ready, busy, misalign);
  modport slave (input req, we, addr, wd, output rd, ready, busy, misalign);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port word memory, synchronous write, combinational read.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[idx] <= wd;
  assign rd = mem[idx];
endmodule

// File: rtl/mem_unit.sv
// mem_unit: unified instruction/data memory with request/ready handshake and wait states.
module mem_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT = 2
) (
  input logic clk,
  input logic reset,
  mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0] idx_q, idx;
  logic [WORD_W-1:0] wd_q, rd_q, mem_rd, cur_wd;
  logic we_q, cur_we, accept, bad, enter_done, misalign_q;
  logic unused;
  assign unused = ^bus.addr[WORD_W-1:AW+2];
  assign accept = state == IDLE && bus.req;
  assign bad = |bus.addr[1:0];
  // With WAIT=0 the access completes straight from IDLE, so take the live bus values then.
  assign idx = state == IDLE ? bus.addr[AW+1:2] : idx_q;
  assign cur_we = state == IDLE ? bus.we : we_q;
  assign cur_wd = state == IDLE ? bus.wd : wd_q;
  assign enter_done = next == DONE && state != DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE: if (bus.req) next = bad ? ERR : (WAIT == 0 ? DONE : mem_pkg::WAIT);
      mem_pkg::WAIT: if (cnt == CNT_W'(1)) next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      we_q <= 1'b0;
      wd_q <= '0;
      rd_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state <= next;
      cnt <= accept ? CNT_W'(WAIT) : (state == mem_pkg::WAIT ? cnt - 1'b1 : cnt);
      if (accept) begin
        idx_q <= bus.addr[AW+1:2];
        we_q <= bus.we;
        wd_q <= bus.wd;
      end
      rd_q <= enter_done && !cur_we ? mem_rd : rd_q;
      misalign_q <= misalign_q | (accept && bad);
    end
  end
  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(enter_done && cur_we && !reset),
    .idx(idx),
    .wd(cur_wd),
    .rd(mem_rd)
  );
  assign bus.rd = rd_q;
  assign bus.ready = state == DONE || state == ERR;
  assign bus.busy = state != IDLE;
  assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed checks of handshake latency, read/write, wrap, misalign and reset abort.
module tb_mem_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int lat, bsy;
  mem_if bus();
  mem_unit #(.DEPTH(64), .WAIT(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d, output int l, output int b);
    l = 0;
    b = 0;
    bus.addr = a;
    bus.we = w;
    bus.wd = d;
    bus.req = 1'b1;
    for (int i = 1; i <= 20 && l == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) b++;
      if (bus.ready) l = i;
    end
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = 32'hFFFF_FFF3;
    bus.wd = 32'h0BAD_0BAD;
  endtask
  initial begin
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wd = '0;
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle_flags", {29'd0, bus.ready, bus.busy, bus.misalign}, 32'd0);
      check("idle_rd", bus.rd, 32'd0);
    end
    access(32'h0C, 1'b1, 32'h8C02_0004, lat, bsy);
    check("wr0c_lat", lat, 3);
    check("wr0c_rd_hold", bus.rd, 32'd0);
    tick(1);
    access(32'h0C, 1'b0, 32'd0, lat, bsy);
    check("rd0c_lat", lat, 3);
    check("rd0c_busy", bsy, 3);
    check("rd0c_data", bus.rd, 32'h8C02_0004);
    tick(1);
    check("rd0c_ready_drop", {31'd0, bus.ready}, 32'd0);
    check("rd0c_busy_drop", {31'd0, bus.busy}, 32'd0);
    access(32'h10, 1'b1, 32'hDEAD_BEEF, lat, bsy);
    check("wr10_lat", lat, 3);
    check("wr10_rd_hold", bus.rd, 32'h8C02_0004);
    tick(1);
    access(32'h10, 1'b0, 32'd0, lat, bsy);
    check("rd10_data", bus.rd, 32'hDEAD_BEEF);
    tick(1);
    access(32'h100, 1'b1, 32'h1234, lat, bsy);
    tick(1);
    access(32'h000, 1'b0, 32'd0, lat, bsy);
    check("wrap_data", bus.rd, 32'h1234);
    tick(1);
    access(32'h0E, 1'b1, 32'h5555_5555, lat, bsy);
    check("mis_lat", lat, 1);
    check("mis_busy", bsy, 1);
    check("mis_flag", {31'd0, bus.misalign}, 32'd1);
    check("mis_rd_hold", bus.rd, 32'h1234);
    tick(3);
    check("mis_sticky", {31'd0, bus.misalign}, 32'd1);
    check("mis_idle_ready", {31'd0, bus.ready}, 32'd0);
    access(32'h0C, 1'b0, 32'd0, lat, bsy);
    check("mis_mem3", bus.rd, 32'h8C02_0004);
    tick(1);
    access(32'h20, 1'b1, 32'hA5A5_A5A5, lat, bsy);
    tick(1);
    bus.addr = 32'h20;
    bus.we = 1'b1;
    bus.wd = 32'h0000_FFFF;
    bus.req = 1'b1;
    tick(1);
    bus.req = 1'b0;
    bus.addr = 32'h0C;
    bus.we = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd1);
    tick(1);
    check("abort_wait_ready", {31'd0, bus.ready}, 32'd0);
    reset = 1'b1;
    tick(1);
    check("abort_ready", {31'd0, bus.ready}, 32'd0);
    check("abort_busy_clr", {31'd0, bus.busy}, 32'd0);
    check("abort_mis_clr", {31'd0, bus.misalign}, 32'd0);
    check("abort_rd_clr", bus.rd, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("abort_no_ready", {30'd0, bus.ready, bus.busy}, 32'd0);
    end
    access(32'h20, 1'b0, 32'd0, lat, bsy);
    check("abort_mem8", bus.rd, 32'hA5A5_A5A5);
    check("abort_rd_lat", lat, 3);
    access(32'h0C, 1'b0, 32'd0, lat, bsy);
    check("b2b_lat", lat, 4);
    check("b2b_busy", bsy, 3);
    check("b2b_data", bus.rd, 32'h8C02_0004);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
